// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencing controller: steps each instruction through
// FETCH/DECODE/EXE/MEM/WB over a shared req/ready memory port.
module mc_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       optCode,
   input  logic [5:0]       funcCode,
   input  logic             cmp,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write_enable,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write_enable,
   output logic [3:0]       alu_op,
   output logic [2:0]       ext_op,
   output logic [2:0]       alu_src,
   output logic [2:0]       nPC_sel,
   output logic [2:0]       regw_dst,
   output logic [2:0]       regw_src,
   output logic [2:0]       width,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_addu, w_subu, w_jr, w_nop, w_ori, w_lui;
   logic             w_lw, w_sw, w_beq, w_j, w_jal, w_ill;
   logic             w_short;
   logic             w_retire;

   always_comb begin
      w_addu = 1'b0;
      w_subu = 1'b0;
      w_jr   = 1'b0;
      w_nop  = 1'b0;
      w_ori  = 1'b0;
      w_lui  = 1'b0;
      w_lw   = 1'b0;
      w_sw   = 1'b0;
      w_beq  = 1'b0;
      w_j    = 1'b0;
      w_jal  = 1'b0;
      w_ill  = 1'b0;
      case (optCode)
         6'b000000: begin
            case (funcCode)
               6'b100001: w_addu = 1'b1;
               6'b100011: w_subu = 1'b1;
               6'b001000: w_jr   = 1'b1;
               6'b000000: w_nop  = 1'b1;
               default:   w_ill  = 1'b1;
            endcase
         end
         6'b001101: w_ori = 1'b1;
         6'b001111: w_lui = 1'b1;
         6'b100011: w_lw  = 1'b1;
         6'b101011: w_sw  = 1'b1;
         6'b000100: w_beq = 1'b1;
         6'b000010: w_j   = 1'b1;
         6'b000011: w_jal = 1'b1;
         default:   w_ill = 1'b1;
      endcase
   end

   // Instructions that finish in DECODE: jumps without link, nop and anything unsupported
   assign w_short = w_j | w_jr | w_nop | w_ill;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (w_short)    w_next = S_FETCH;
            else if (w_jal) w_next = S_WB;
            else            w_next = S_EXE;
         end
         S_EXE: begin
            if (w_lw || w_sw) w_next = S_MEM;
            else if (w_beq)   w_next = S_FETCH;
            else              w_next = S_WB;
         end
         S_MEM: begin
            if (!mem_ready) w_next = S_MEM;
            else if (w_lw)  w_next = S_WB;
            else            w_next = S_FETCH;
         end
         S_WB:    w_next = S_FETCH;
         default: w_next = S_FETCH;
      endcase
   end

   // Every return to FETCH from a later step is exactly one retirement
   assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      mem_req          = 1'b0;
      mem_write_enable = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write_enable = 1'b0;
      illegal          = 1'b0;
      alu_op           = '0;
      ext_op           = '0;
      alu_src          = '0;
      nPC_sel          = '0;
      regw_dst         = '0;
      regw_src         = '0;
      if (reset) begin
         // ALU/EXT fields stay valid from EXE through WB so the address and result remain stable
         if (r_state inside {S_EXE, S_MEM, S_WB}) begin
            if (w_subu) alu_op = 4'd1;
            if (w_ori) begin
               alu_src = 3'd1;
               alu_op  = 4'd2;
            end
            if (w_lui) ext_op = 3'd2;
            if (w_lw || w_sw) begin
               ext_op  = 3'd1;
               alu_src = 3'd1;
            end
            if (w_beq) begin
               ext_op = 3'd1;
               alu_op = 4'd3;
            end
         end
         case (r_state)
            S_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
            end
            S_DECODE: begin
               if (w_short) begin
                  pc_write = 1'b1;
                  illegal  = w_ill;
                  if (w_j)       nPC_sel = 3'd2;
                  else if (w_jr) nPC_sel = 3'd3;
               end
            end
            S_EXE: begin
               if (w_beq) begin
                  pc_write = 1'b1;
                  nPC_sel  = cmp ? 3'd1 : 3'd0;
               end
            end
            S_MEM: begin
               mem_req          = 1'b1;
               mem_write_enable = w_sw;
            end
            S_WB: begin
               reg_write_enable = 1'b1;
               pc_write         = 1'b1;
               if (w_jal)               nPC_sel  = 3'd2;
               if (w_addu || w_subu)    regw_dst = 3'd1;
               else if (w_jal)          regw_dst = 3'd2;
               if (w_lw)                regw_src = 3'd1;
               else if (w_lui)          regw_src = 3'd2;
               else if (w_jal)          regw_src = 3'd3;
            end
            default: ;
         endcase
      end
   end

   assign width     = '0;
   assign state     = r_state;
   assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction step plan model, one negedge compare process,
// plus literal latency/counter/reset checks.
module tb_mc_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  optCode, funcCode;
   logic        cmp, mem_ready;
   logic        mem_req, mem_write_enable, ir_write, pc_write, reg_write_enable, illegal;
   logic [3:0]  alu_op;
   logic [2:0]  ext_op, alu_src, nPC_sel, regw_dst, regw_src, width, state;
   logic [31:0] instr_cnt;

   logic        d2_mem_req, d2_mem_write_enable, d2_ir_write, d2_pc_write, d2_reg_write_enable, d2_illegal;
   logic [3:0]  d2_alu_op;
   logic [2:0]  d2_ext_op, d2_alu_src, d2_nPC_sel, d2_regw_dst, d2_regw_src, d2_width, d2_state;
   logic [1:0]  d2_instr_cnt;

   mc_ctrl #(.CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .optCode(optCode), .funcCode(funcCode), .cmp(cmp),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write_enable(mem_write_enable),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write_enable(reg_write_enable),
      .alu_op(alu_op), .ext_op(ext_op), .alu_src(alu_src), .nPC_sel(nPC_sel),
      .regw_dst(regw_dst), .regw_src(regw_src), .width(width), .state(state),
      .illegal(illegal), .instr_cnt(instr_cnt)
   );

   // Narrow counter instance exercises wrap-around
   mc_ctrl #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .optCode(optCode), .funcCode(funcCode), .cmp(cmp),
      .mem_ready(mem_ready), .mem_req(d2_mem_req), .mem_write_enable(d2_mem_write_enable),
      .ir_write(d2_ir_write), .pc_write(d2_pc_write), .reg_write_enable(d2_reg_write_enable),
      .alu_op(d2_alu_op), .ext_op(d2_ext_op), .alu_src(d2_alu_src), .nPC_sel(d2_nPC_sel),
      .regw_dst(d2_regw_dst), .regw_src(d2_regw_src), .width(d2_width), .state(d2_state),
      .illegal(d2_illegal), .instr_cnt(d2_instr_cnt)
   );

   typedef enum int {K_ADDU, K_SUBU, K_JR, K_NOP, K_ORI, K_LUI, K_LW, K_SW,
                     K_BEQ, K_J, K_JAL, K_ILL} kind_t;

   typedef struct {
      logic [2:0]  st;
      logic        mreq, mwe, irw, pcw, rwe, ill;
      logic [3:0]  aop;
      logic [2:0]  ext, asrc, npc, dst, src;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
      kind_t k;
      k = K_ILL;
      if (op == 6'd0) begin
         if (fn == 6'b100001)      k = K_ADDU;
         else if (fn == 6'b100011) k = K_SUBU;
         else if (fn == 6'b001000) k = K_JR;
         else if (fn == 6'b000000) k = K_NOP;
      end
      else if (op == 6'b001101) k = K_ORI;
      else if (op == 6'b001111) k = K_LUI;
      else if (op == 6'b100011) k = K_LW;
      else if (op == 6'b101011) k = K_SW;
      else if (op == 6'b000100) k = K_BEQ;
      else if (op == 6'b000010) k = K_J;
      else if (op == 6'b000011) k = K_JAL;
      return k;
   endfunction

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e = '{default: '0};
      e.st  = st;
      e.cnt = model_cnt;
      return e;
   endfunction

   // Datapath fields an instruction needs while its ALU/EXT result is in use
   function automatic exp_t with_fields(input kind_t k, input exp_t ein);
      exp_t e;
      e = ein;
      case (k)
         K_SUBU:     e.aop = 4'd1;
         K_ORI:      begin e.asrc = 3'd1; e.aop = 4'd2; end
         K_LUI:      e.ext = 3'd2;
         K_LW, K_SW: begin e.ext = 3'd1; e.asrc = 3'd1; end
         K_BEQ:      begin e.ext = 3'd1; e.aop = 4'd3; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one instruction through its step plan and queues the expected outputs per cycle.
   // With abort set it stops at the first MEM cycle without queueing it.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic cmpv,
                            input int fw, input int mw, input bit abort, output int cycles);
      kind_t k;
      exp_t  e;
      k = classify(op, fn);
      cycles = 0;
      optCode = op;
      funcCode = fn;
      cmp = cmpv;
      for (int i = 0; i <= fw; i++) begin
         mem_ready = (i == fw);
         e = blank(3'd0);
         e.mreq = 1'b1;
         e.irw  = (i == fw);
         exp_q.push_back(e);
         step();
         cycles++;
      end
      mem_ready = 1'($urandom_range(0, 1));
      e = blank(3'd1);
      if (k inside {K_J, K_JR, K_NOP, K_ILL}) begin
         e.pcw = 1'b1;
         e.ill = (k == K_ILL);
         e.npc = (k == K_J) ? 3'd2 : (k == K_JR) ? 3'd3 : 3'd0;
         exp_q.push_back(e);
         step();
         cycles++;
         model_cnt++;
         return;
      end
      exp_q.push_back(e);
      step();
      cycles++;
      if (k != K_JAL) begin
         mem_ready = 1'($urandom_range(0, 1));
         e = with_fields(k, blank(3'd2));
         if (k == K_BEQ) begin
            e.pcw = 1'b1;
            e.npc = cmpv ? 3'd1 : 3'd0;
         end
         exp_q.push_back(e);
         step();
         cycles++;
         if (k == K_BEQ) begin
            model_cnt++;
            return;
         end
         if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
               mem_ready = (i == mw);
               if (abort) return;
               e = with_fields(k, blank(3'd3));
               e.mreq = 1'b1;
               e.mwe  = (k == K_SW);
               exp_q.push_back(e);
               step();
               cycles++;
            end
            if (k == K_SW) begin
               model_cnt++;
               return;
            end
         end
      end
      mem_ready = 1'($urandom_range(0, 1));
      e = (k == K_JAL) ? blank(3'd4) : with_fields(k, blank(3'd4));
      e.rwe = 1'b1;
      e.pcw = 1'b1;
      case (k)
         K_ADDU, K_SUBU: begin e.dst = 3'd1; e.src = 3'd0; end
         K_LUI:          e.src = 3'd2;
         K_LW:           e.src = 3'd1;
         K_JAL:          begin e.dst = 3'd2; e.src = 3'd3; e.npc = 3'd2; end
         default: ;
      endcase
      exp_q.push_back(e);
      step();
      cycles++;
      model_cnt++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("state",     32'(state),            32'(e.st));
         chk("mem_req",   32'(mem_req),          32'(e.mreq));
         chk("mem_we",    32'(mem_write_enable), 32'(e.mwe));
         chk("ir_write",  32'(ir_write),         32'(e.irw));
         chk("pc_write",  32'(pc_write),         32'(e.pcw));
         chk("reg_we",    32'(reg_write_enable), 32'(e.rwe));
         chk("illegal",   32'(illegal),          32'(e.ill));
         chk("alu_op",    32'(alu_op),           32'(e.aop));
         chk("ext_op",    32'(ext_op),           32'(e.ext));
         chk("alu_src",   32'(alu_src),          32'(e.asrc));
         chk("nPC_sel",   32'(nPC_sel),          32'(e.npc));
         chk("regw_dst",  32'(regw_dst),         32'(e.dst));
         chk("regw_src",  32'(regw_src),         32'(e.src));
         chk("width",     32'(width),            32'd0);
         chk("instr_cnt", instr_cnt,             e.cnt);
         chk("cnt_w2",    32'(d2_instr_cnt),     32'(e.cnt[1:0]));
         chk("state_w2",  32'(d2_state),         32'(e.st));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      reset = 1'b1;
      optCode = '0;
      funcCode = '0;
      cmp = 1'b0;
      mem_ready = 1'b0;
      #1 reset = 1'b0;
      mem_ready = 1'b1;
      #2;
      chk("rst_state",    32'(state),            32'd0);
      chk("rst_mem_req",  32'(mem_req),          32'd0);
      chk("rst_ir_write", 32'(ir_write),         32'd0);
      chk("rst_pc_write", 32'(pc_write),         32'd0);
      chk("rst_cnt",      instr_cnt,             32'd0);
      step();
      step();
      reset = 1'b1;

      run_instr(6'b000000, 6'b100001, 1'b0, 0, 0, 1'b0, cyc); chk("lat_addu", 32'(cyc), 32'd4);
      chk("cnt_after_addu", instr_cnt, 32'd1);
      run_instr(6'b000000, 6'b100011, 1'b1, 0, 0, 1'b0, cyc); chk("lat_subu", 32'(cyc), 32'd4);
      run_instr(6'b001101, 6'b001000, 1'b0, 0, 0, 1'b0, cyc); chk("lat_ori",  32'(cyc), 32'd4);
      run_instr(6'b001111, 6'b000000, 1'b1, 0, 0, 1'b0, cyc); chk("lat_lui",  32'(cyc), 32'd4);
      run_instr(6'b101011, 6'b100011, 1'b0, 0, 0, 1'b0, cyc); chk("lat_sw",   32'(cyc), 32'd4);
      run_instr(6'b100011, 6'b000000, 1'b0, 2, 3, 1'b0, cyc); chk("lat_lw_wait", 32'(cyc), 32'd10);
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0, cyc); chk("lat_beq_t", 32'(cyc), 32'd3);
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0, cyc); chk("lat_beq_n", 32'(cyc), 32'd3);
      run_instr(6'b000011, 6'b000000, 1'b1, 0, 0, 1'b0, cyc); chk("lat_jal",  32'(cyc), 32'd3);
      run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, 1'b0, cyc); chk("lat_jr",   32'(cyc), 32'd2);
      run_instr(6'b000010, 6'b000000, 1'b0, 1, 0, 1'b0, cyc); chk("lat_j_wait", 32'(cyc), 32'd3);
      run_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0, cyc); chk("lat_nop",  32'(cyc), 32'd2);
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0, cyc); chk("lat_ill",  32'(cyc), 32'd2);
      run_instr(6'b000000, 6'b100000, 1'b1, 0, 0, 1'b0, cyc); chk("lat_ill_r", 32'(cyc), 32'd2);
      run_instr(6'b100011, 6'b101011, 1'b0, 0, 0, 1'b0, cyc); chk("lat_lw",   32'(cyc), 32'd5);
      chk("cnt_15",    instr_cnt,         32'd15);
      chk("cnt_w2_15", 32'(d2_instr_cnt), 32'd3);

      run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1, cyc); chk("cycles_to_mem", 32'(cyc), 32'd3);
      #1;
      chk("mid_mem_req", 32'(mem_req),          32'd1);
      chk("mid_mem_we",  32'(mem_write_enable), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("arst_mem_req", 32'(mem_req),          32'd0);
      chk("arst_mem_we",  32'(mem_write_enable), 32'd0);
      chk("arst_state",   32'(state),            32'd0);
      chk("arst_cnt",     instr_cnt,             32'd0);
      chk("arst_pc_wr",   32'(pc_write),         32'd0);
      chk("arst_reg_we",  32'(reg_write_enable), 32'd0);
      model_cnt = 0;
      step();
      reset = 1'b1;

      run_instr(6'b000000, 6'b100001, 1'b0, 0, 0, 1'b0, cyc); chk("lat_addu_post", 32'(cyc), 32'd4);
      chk("cnt_post_rst", instr_cnt, 32'd1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
